// File: rtl/mul_16bit_pkg.sv
// mul_16bit_pkg: widths and FSM states shared by the shift-add multiplier.
package mul_16bit_pkg;
    localparam int A_W = 16;
    localparam int B_W = 8;
    localparam int P_W = A_W + B_W;
    localparam int C_W = $clog2(B_W + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mul_16bit_step.sv
// mul_16bit_step: one shift-add stage, conditionally adds the shifted multiplicand into acc.
module mul_16bit_step import mul_16bit_pkg::*; (
    input  logic [P_W-1:0] acc,
    input  logic [P_W-1:0] a_reg,
    input  logic           b_lsb,
    output logic [P_W-1:0] acc_nxt
);
    assign acc_nxt = b_lsb ? acc + a_reg : acc;
endmodule

// File: rtl/mul_16bit_seq.sv
// mul_16bit_seq: sequential 16x8 shift-add multiplier with valid/ready on both sides.
// Define MUL_ADD_REM_EN to add port R and produce A*B+R.
module mul_16bit_seq import mul_16bit_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
`ifdef MUL_ADD_REM_EN
    input  logic [B_W-1:0] R,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product
);
    state_t         state_q, state_d;
    logic [P_W-1:0] a_q, a_d, acc_q, acc_d, acc_step, preload;
    logic [B_W-1:0] b_q, b_d;
    logic [C_W-1:0] cnt_q, cnt_d;

`ifdef MUL_ADD_REM_EN
    assign preload = P_W'(R);
`else
    assign preload = '0;
`endif

    mul_16bit_step u_step (
        .acc     (acc_q),
        .a_reg   (a_q),
        .b_lsb   (b_q[0]),
        .acc_nxt (acc_step)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign product   = out_valid ? acc_q : '0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = BUSY;
                a_d     = {{B_W{1'b0}}, A};
                b_d     = B;
                acc_d   = preload;
                cnt_d   = '0;
            end
            BUSY: begin
                acc_d   = acc_step;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + C_W'(1);
                state_d = cnt_q == C_W'(B_W - 1) ? DONE : BUSY;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mul_16bit_seq.sv
// tb_mul_16bit_seq: self-checking bench for mul_16bit_seq (honours MUL_ADD_REM_EN).
module tb_mul_16bit_seq;
    import mul_16bit_pkg::*;
`ifdef MUL_ADD_REM_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic           clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [A_W-1:0] a_i = '0;
    logic [B_W-1:0] b_i = '0, r_i = '0;
    logic           in_ready, out_valid;
    logic [P_W-1:0] product;
    int             errors = 0, checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  r;
        logic [23:0] ab;
        int          hold;
        string       name;
    } vec_t;

    mul_16bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_i),
        .B         (b_i),
`ifdef MUL_ADD_REM_EN
        .R         (r_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [P_W-1:0] model(input logic [15:0] a, input logic [7:0] b, input logic [7:0] r);
        longint p;
        p = longint'(a) * longint'(b) + (REM_EN ? longint'(r) : 64'd0);
        return p[P_W-1:0];
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] r,
                          input logic [23:0] exp, input int hold, input string name);
        int cyc;
        logic [P_W-1:0] held;
        check({name, " idle_ready"}, 32'(in_ready), 32'd1);
        a_i = a; b_i = b; r_i = r;
        out_ready = (hold == 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_i = 16'($urandom); b_i = 8'($urandom); r_i = 8'($urandom);
        check({name, " busy_ready"}, 32'(in_ready), 32'd0);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd9);
        check({name, " product"}, 32'(product), 32'(exp));
        held = product;
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " hold_valid"}, 32'(out_valid), 32'd1);
            check({name, " hold_product"}, 32'(product), 32'(held));
            check({name, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, " exit_valid"}, 32'(out_valid), 32'd0);
        check({name, " exit_product"}, 32'(product), 32'd0);
        check({name, " exit_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{16'hFFFF, 8'hFF, 8'h00, 24'hFEFF01, 0, "max"};
        vecs[1] = '{16'h1234, 8'h00, 8'h00, 24'h000000, 0, "b_zero"};
        vecs[2] = '{16'h0001, 8'h80, 8'h00, 24'h000080, 0, "b_msb"};
        vecs[3] = '{16'h8000, 8'h02, 8'h00, 24'h010000, 0, "carry"};
        vecs[4] = '{16'h0123, 8'h0D, 8'h05, 24'h000EC7, 0, "rem"};
        vecs[5] = '{16'h0000, 8'hFF, 8'h00, 24'h000000, 0, "a_zero"};
        vecs[6] = '{16'h00FF, 8'hFF, 8'h00, 24'h00FE01, 5, "backpressure"};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset product", 32'(product), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].ab + (REM_EN ? 24'(vecs[i].r) : 24'd0), vecs[i].hold, vecs[i].name);

        a_i = 16'd7; b_i = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort product", 32'(product), 32'd0);
        run_op(16'd3, 8'd5, 8'd0, 24'h00000F, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [7:0]  b, r;
            a = 16'($urandom);
            b = 8'($urandom);
            r = 8'($urandom);
            if (i % 8 == 0) b = 8'hFF;
            if (i % 8 == 1) a = 16'hFFFF;
            run_op(a, b, r, model(a, b, r), int'($urandom_range(0, 2)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
